// File: rtl/mpsoc_bb_ext_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : mpsoc_bb_ext_arbiter_if
//  Description : Bundle of the per-node external Blackbone-bus request/response
//                signals plus the shared memory-port signals of the external
//                bus arbiter.
//                  slave  : arbiter view (consumes node requests and mem_dout,
//                           drives responses, memory strobes and busy)
//                  master : environment view (tiles + memory)
//                Ports carried:
//                  bb_ext_addr_i/din_i/en_i/we_i  per-node request
//                  bb_ext_dout_o/ack_o            per-node response
//                  mem_addr/mem_din/mem_en/mem_we memory command
//                  mem_dout                       memory read data
//                  busy                           arbiter not idle
//  Revision    : 1.0 - initial release
// ============================================================================
interface mpsoc_bb_ext_arbiter_if #(
    parameter int AW    = 32,
    parameter int DW    = 32,
    parameter int NODES = 4
) ();

    logic [NODES-1:0][AW-1:0] bb_ext_addr_i;
    logic [NODES-1:0][DW-1:0] bb_ext_din_i;
    logic [NODES-1:0]         bb_ext_en_i;
    logic [NODES-1:0]         bb_ext_we_i;
    logic [NODES-1:0][DW-1:0] bb_ext_dout_o;
    logic [NODES-1:0]         bb_ext_ack_o;
    logic [AW-1:0]            mem_addr;
    logic [DW-1:0]            mem_din;
    logic                     mem_en;
    logic                     mem_we;
    logic [DW-1:0]            mem_dout;
    logic                     busy;

    modport slave (
        input  bb_ext_addr_i, bb_ext_din_i, bb_ext_en_i, bb_ext_we_i, mem_dout,
        output bb_ext_dout_o, bb_ext_ack_o, mem_addr, mem_din, mem_en, mem_we, busy
    );

    modport master (
        output bb_ext_addr_i, bb_ext_din_i, bb_ext_en_i, bb_ext_we_i, mem_dout,
        input  bb_ext_dout_o, bb_ext_ack_o, mem_addr, mem_din, mem_en, mem_we, busy
    );

endinterface
`default_nettype wire

// File: rtl/mpsoc_bb_ext_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mpsoc_bb_ext_arbiter
//  Description : Round-robin arbiter/sequencer sharing one external memory
//                port among NODES tile masters. One access outstanding at a
//                time: IDLE (grant) -> ISSUE (mem_en) -> WAIT (MEM_LATENCY
//                cycles, capture mem_dout) -> ACK (one-cycle ack to grantee).
//  Ports       : clk  - system clock
//                rst  - synchronous active-high reset
//                bus  - slave modport of mpsoc_bb_ext_arbiter_if
//  Revision    : 1.0 - initial release
// ============================================================================
module mpsoc_bb_ext_arbiter #(
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int NODES       = 4,
    parameter int MEM_LATENCY = 2
) (
    input  wire logic               clk,
    input  wire logic               rst,
    mpsoc_bb_ext_arbiter_if.slave   bus
);

    localparam int         c_GW     = (NODES > 1) ? $clog2(NODES) : 1;
    localparam logic [3:0] c_LAT_M1 = 4'(MEM_LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_ACK   = 2'd3
    } state_t;

    state_t                   r_state;
    logic [c_GW-1:0]          r_ptr;
    logic [c_GW-1:0]          r_grant;
    logic [3:0]               r_cnt;
    logic [AW-1:0]            r_mem_addr;
    logic [DW-1:0]            r_mem_din;
    logic                     r_mem_we;
    logic                     r_mem_en;
    logic                     r_busy;
    logic [NODES-1:0]         r_ack;
    logic [NODES-1:0][DW-1:0] r_dout;

    logic                     w_found;
    logic [c_GW-1:0]          w_pick;
    logic [c_GW-1:0]          w_cand;

    // Node index 'off' positions after the pointer, wrapping modulo NODES
    // (NODES need not be a power of two).
    function automatic logic [c_GW-1:0] f_rr_idx(input logic [c_GW-1:0] ptr, input int off);
        int s;
        s = (int'(ptr) + off) % NODES;
        return c_GW'(s);
    endfunction

    // Scan starts just after the last-served node so the node that was
    // served most recently is considered last.
    always_comb begin
        w_found = 1'b0;
        w_pick  = r_ptr;
        w_cand  = r_ptr;
        for (int k = 1; k <= NODES; k++) begin
            w_cand = f_rr_idx(r_ptr, k);
            if (!w_found && bus.bb_ext_en_i[w_cand]) begin
                w_found = 1'b1;
                w_pick  = w_cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_ptr      <= c_GW'(NODES - 1);
            r_grant    <= '0;
            r_cnt      <= '0;
            r_mem_addr <= '0;
            r_mem_din  <= '0;
            r_mem_we   <= 1'b0;
            r_mem_en   <= 1'b0;
            r_busy     <= 1'b0;
            r_ack      <= '0;
            r_dout     <= '0;
        end else begin
            r_ack <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_grant    <= w_pick;
                        r_mem_addr <= bus.bb_ext_addr_i[w_pick];
                        r_mem_din  <= bus.bb_ext_din_i[w_pick];
                        r_mem_we   <= bus.bb_ext_we_i[w_pick];
                        r_mem_en   <= 1'b1;
                        r_busy     <= 1'b1;
                        r_state    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_mem_en <= 1'b0;
                    r_cnt    <= c_LAT_M1;
                    r_state  <= S_WAIT;
                end
                S_WAIT: begin
                    // Counter loaded with latency-1, so this state spans
                    // exactly MEM_LATENCY cycles before data is captured.
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        r_dout[r_grant] <= bus.mem_dout;
                        r_ack[r_grant]  <= 1'b1;
                        r_state         <= S_ACK;
                    end
                end
                S_ACK: begin
                    r_ptr   <= r_grant;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.mem_addr      = r_mem_addr;
    assign bus.mem_din       = r_mem_din;
    assign bus.mem_we        = r_mem_we;
    assign bus.mem_en        = r_mem_en;
    assign bus.busy          = r_busy;
    assign bus.bb_ext_ack_o  = r_ack;
    assign bus.bb_ext_dout_o = r_dout;

endmodule
`default_nettype wire

// File: doc/mpsoc_bb_ext_arbiter.md
Name: mpsoc_bb_ext_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one external Blackbone-bus memory port among NODES tile-side external bus masters.
- Sits between the per-node external bus outputs of the 2D-mesh MSP430 MPSoC top and a single off-tile memory.
- Serialises accesses with exactly one access outstanding. Each access has fixed memory latency.
- Returns read data, and a one-cycle acknowledge, to the granted node only.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- NODES, 4, number of requesting tiles (2..16).
- MEM_LATENCY, 2, cycles from mem_en to valid mem_dout (1..15).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- bb_ext_addr_i  in  [NODES-1:0][AW-1:0]  per-node access address.
- bb_ext_din_i  in  [NODES-1:0][DW-1:0]  per-node write data.
- bb_ext_en_i  in  [NODES-1:0]  per-node request; held until ack.
- bb_ext_we_i  in  [NODES-1:0]  per-node write enable, qualified by en.
- bb_ext_dout_o  out  [NODES-1:0][DW-1:0]  per-node read data, valid with ack.
- bb_ext_ack_o  out  [NODES-1:0]  one-cycle access-complete pulse.
- mem_addr  out  AW  memory address.
- mem_din  out  DW  memory write data.
- mem_en  out  1  memory access strobe, one cycle per access.
- mem_we  out  1  memory write enable, valid only with mem_en.
- mem_dout  in  DW  memory read data.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Clock and reset are fixed: one clock, clk; reset rst is synchronous and active-high.
- Reset values:
  - FSM goes to IDLE.
  - All outputs are 0: ack, dout, mem_en, mem_we, mem_addr, mem_din, busy.
  - The round-robin pointer is NODES-1, so node 0 has top priority first.
  - The wait counter is 0.
- FSM states: IDLE, ISSUE, WAIT, ACK.
- IDLE:
  - If any en bit is set, pick the first set bit scanning from pointer+1 upward with wrap-around.
  - Register grant index g. Latch addr[g], din[g] and we[g] into the mem_addr/mem_din/mem_we registers.
  - Go to ISSUE. With no requests, stay in IDLE.
- ISSUE (one cycle):
  - mem_en=1; mem_we=latched we.
  - Load the counter with MEM_LATENCY-1; go to WAIT.
- WAIT:
  - mem_en=0.
  - While the counter is non-zero, decrement it.
  - When the counter is 0, capture mem_dout into dout[g] and go to ACK.
  - WAIT therefore lasts exactly MEM_LATENCY cycles.
- ACK (one cycle):
  - ack[g]=1; set pointer=g; go to IDLE.
  - On writes, dout[g] still receives the sampled mem_dout; its value is don't-care to the requester.
- Timing: a request seen in IDLE at cycle t gives mem_en at t+1, capture at t+1+MEM_LATENCY and ack at t+2+MEM_LATENCY.
- Throughput: minimum spacing between grants is MEM_LATENCY+3 cycles.
- mem_addr, mem_din and mem_we hold their latched values from ISSUE until the next grant. The memory side must only qualify them with mem_en.
- Each dout[n] holds its last captured value until node n's next ack. Other nodes' dout never change.
- Requester contract:
  - addr, din and we are stable while en=1.
  - The requester clears en at the clock edge where it samples ack=1.
  - en=1 during the IDLE cycle after ACK is a new request.
- Request withdrawn (en dropped) after grant: the access still completes and ack is still pulsed.
- Simultaneous requests: only one grant per IDLE cycle. Losers wait; their en bits stay asserted.
- Fairness: a node that keeps requesting is served within NODES grants.
- Reset mid-operation (any state):
  - Next cycle is IDLE with all outputs 0.
  - No ack for the aborted access; no further mem_en.
  - The pointer returns to NODES-1.
- The grant index and pointer are $clog2(NODES) bits wide. The round-robin scan wraps modulo NODES.

Test Plan:
- Single read, MEM_LATENCY=2, node 2, addr=0x100, memory returns 0xCAFE0001:
  - mem_en=1 with mem_addr=0x100 and mem_we=0 one cycle after en.
  - ack[2]=1 four cycles after en; dout[2]=0xCAFE0001.
  - No other ack bits assert.
- All four nodes request in the same cycle after reset -> grant order 0,1,2,3; ack pulses spaced exactly 5 cycles apart.
- Pointer=1 (node 1 just served), nodes 1 and 3 both requesting -> node 3 granted before node 1; then node 1; no starvation.
- Node 0 writes 0xDEADBEEF to 0x20, then node 1 reads 0x20:
  - First access has mem_we=1 and mem_din=0xDEADBEEF.
  - Second access has mem_we=0; dout[1]=0xDEADBEEF.
  - dout[0] is unchanged by the second access.
- rst asserted during WAIT -> next cycle busy=0, no ack, mem_en=0; after release, a pending node 3 request is granted normally.
- MEM_LATENCY=1, node 1 requesting back-to-back -> mem_en every 4 cycles; each ack occurs exactly 3 cycles after the corresponding en is seen in IDLE.
